// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, one bit per clock, start/busy/done handshake.
// Optional macro SERIAL_SUBTRACTOR_ADD_EN adds an `add` port selecting A + B + Bin instead.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic             add,
`endif
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic [WIDTH:0]   Result,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_add;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    logic             w_add_in;
    logic             w_load;
    logic             w_last;
    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_d;
    logic             w_br_next;
    logic             w_v;
    logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    assign w_add_in = add;
`else
    assign w_add_in = 1'b0;
`endif

    // A new operation is accepted from IDLE, and also from DONE for back-to-back use.
    assign w_load  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last  = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);
    assign w_bit_a = r_a[0];
    assign w_bit_b = r_b[0];
    assign w_d     = w_bit_a ^ w_bit_b ^ r_br;

    // r_br holds borrow in subtract mode and carry in add mode.
    assign w_br_next = r_add ? ((w_bit_a & w_bit_b) | (r_br & (w_bit_a ^ w_bit_b)))
                             : ((~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_br));

    // w_d is the final MSB of the difference on the completion edge.
    assign w_v = r_add ? (~(r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d))
                       : ((r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d));

    assign w_acc_next = {w_d, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_add   <= 1'b0;
        end else if (w_load) begin
            r_a     <= A;
            r_b     <= B;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_br    <= Bin;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_add   <= w_add_in;
        end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            r_br  <= w_br_next;
        end
    end

    // Visible results change only on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_v    <= 1'b0;
        end else if (w_last) begin
            r_d    <= w_acc_next;
            r_bout <= w_br_next;
            r_v    <= w_v;
        end
    end

    assign D      = r_d;
    assign Bout   = r_bout;
    assign V      = r_v;
    assign Result = {r_bout, r_d};

endmodule
